// File: rtl/shift_rot_pipe.sv
// Pipelined barrel shifter/rotator: one register stage per shift-amount bit, each stage
// optionally shifting by 2^k, with a global valid/ready advance across all stages.
module shift_rot_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   shift_amnt,
    input  logic [1:0]                 mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_carry,
    output logic                       out_zero
);
    localparam int unsigned AW = $clog2(WIDTH);

    localparam logic [1:0] ModeRol = 2'b00;
    localparam logic [1:0] ModeSll = 2'b01;
    localparam logic [1:0] ModeRor = 2'b10;
    localparam logic [1:0] ModeSrl = 2'b11;

    logic adv;

    // Returns {carry, data} for a single shift/rotate by s bits.
    function automatic logic [WIDTH:0] stage_op(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       m,
                                                input int unsigned      s);
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] t;
        res = d;
        t   = d >> (s - 1);
        case (m)
            ModeRol: begin
                res = (d << s) | (d >> (WIDTH - s));
                t   = d >> (WIDTH - s);
            end
            ModeSll: begin
                res = d << s;
                t   = d >> (WIDTH - s);
            end
            ModeRor: res = (d >> s) | (d << (WIDTH - s));
            ModeSrl: res = d >> s;
            default: res = d;
        endcase
        return {t[0], res};
    endfunction

    for (genvar k = 0; k < AW; k++) begin : g_stage
        localparam int unsigned S  = 1 << k;
        // Amount bits still relevant when entering this stage: k .. AW-1.
        localparam int unsigned RW = AW - k;

        logic             in_v;
        logic [WIDTH-1:0] in_d;
        logic             in_c;
        logic [1:0]       in_m;
        logic [RW-1:0]    in_a;

        logic             valid_q;
        logic [WIDTH-1:0] data_q, data_d;
        logic             carry_q, carry_d;
        logic             zero_q, zero_d;

        if (k == 0) begin : g_src
            assign in_v = in_valid;
            assign in_d = in_data;
            assign in_c = 1'b0;
            assign in_m = mode;
            assign in_a = shift_amnt;
        end else begin : g_src
            assign in_v = g_stage[k-1].valid_q;
            assign in_d = g_stage[k-1].data_q;
            assign in_c = g_stage[k-1].carry_q;
            assign in_m = g_stage[k-1].g_fwd.mode_q;
            assign in_a = g_stage[k-1].g_fwd.amnt_q;
        end

        always_comb begin
            data_d  = in_d;
            carry_d = in_c;
            if (in_a[0]) begin
                {carry_d, data_d} = stage_op(in_d, in_m, S);
            end
            zero_d = (data_d == '0);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                carry_q <= 1'b0;
                zero_q  <= 1'b0;
            end else if (adv) begin
                valid_q <= in_v;
                data_q  <= data_d;
                carry_q <= carry_d;
                zero_q  <= zero_d;
            end
        end

        // Mode and the not-yet-consumed amount bits travel only to stages that need them.
        if (k < AW - 1) begin : g_fwd
            logic [1:0]    mode_q;
            logic [RW-2:0] amnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    mode_q <= '0;
                    amnt_q <= '0;
                end else if (adv) begin
                    mode_q <= in_m;
                    amnt_q <= in_a[RW-1:1];
                end
            end
        end
    end

    assign adv       = !g_stage[AW-1].valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = g_stage[AW-1].valid_q;
    assign out_data  = g_stage[AW-1].data_q;
    assign out_carry = g_stage[AW-1].carry_q;
    assign out_zero  = g_stage[AW-1].zero_q;

endmodule

// File: tb/tb_shift_rot_pipe.sv
// Bench for shift_rot_pipe: directed vectors, stall/reset scenarios and a random stream,
// with a scoreboard per instance fed by a bit-serial reference model.
module tb_shift_rot_pipe;
    typedef struct packed {
        logic [31:0] d;
        logic        c;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v16 = 1'b0, rdy16, or16 = 1'b1, ov16, oc16, oz16;
    logic [15:0] d16 = '0, od16;
    logic [3:0]  a16 = '0;
    logic [1:0]  m16 = '0;

    logic        v32 = 1'b0, rdy32, or32 = 1'b1, ov32, oc32, oz32;
    logic [31:0] d32 = '0, od32;
    logic [4:0]  a32 = '0;
    logic [1:0]  m32 = '0;

    int n_cmp = 0;
    int n_err = 0;
    int n_out16 = 0;
    exp_t q16[$];
    exp_t q32[$];

    shift_rot_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_data(d16),
        .shift_amnt(a16), .mode(m16), .out_valid(ov16), .out_ready(or16),
        .out_data(od16), .out_carry(oc16), .out_zero(oz16)
    );

    shift_rot_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_data(d32),
        .shift_amnt(a32), .mode(m32), .out_valid(ov32), .out_ready(or32),
        .out_data(od32), .out_carry(oc32), .out_zero(oz32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Shifts one bit at a time; carry is the last bit that fell off.
    function automatic exp_t model(input int w, input logic [31:0] d, input logic [1:0] m,
                                   input int n);
        logic [31:0] x;
        logic [31:0] t;
        logic [31:0] mask;
        logic        c;
        logic        fill;
        exp_t        r;
        mask = 32'hFFFF_FFFF >> (32 - w);
        x    = d & mask;
        c    = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!m[1]) begin
                t    = x >> (w - 1);
                c    = t[0];
                fill = m[0] ? 1'b0 : c;
                x    = ((x << 1) | {31'b0, fill}) & mask;
            end else begin
                c    = x[0];
                fill = m[0] ? 1'b0 : c;
                x    = (x >> 1) | ({31'b0, fill} << (w - 1));
            end
        end
        r.d = x;
        r.c = c;
        r.z = (x == 32'b0);
        return r;
    endfunction

    // Scoreboards and output-hold checks, sampled mid-cycle.
    logic        st16 = 1'b0, st32 = 1'b0;
    logic [15:0] hd16;
    logic [31:0] hd32;
    logic        hc16, hz16, hc32, hz32;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q16.delete();
            q32.delete();
            st16 = 1'b0;
            st32 = 1'b0;
        end else begin
            if (st16) begin
                check("hold16_v", 32'(ov16), 32'd1);
                check("hold16_d", 32'(od16), 32'(hd16));
                check("hold16_cz", 32'({oc16, oz16}), 32'({hc16, hz16}));
            end
            if (st32) begin
                check("hold32_v", 32'(ov32), 32'd1);
                check("hold32_d", od32, hd32);
                check("hold32_cz", 32'({oc32, oz32}), 32'({hc32, hz32}));
            end
            st16 = ov16 && !or16;
            hd16 = od16; hc16 = oc16; hz16 = oz16;
            st32 = ov32 && !or32;
            hd32 = od32; hc32 = oc32; hz32 = oz32;

            if (ov16 && or16) begin
                n_out16++;
                if (q16.size() == 0) begin
                    check("sb16_underflow", 32'd1, 32'd0);
                end else begin
                    e = q16.pop_front();
                    check("sb16_data", 32'(od16), e.d);
                    check("sb16_carry", 32'(oc16), 32'(e.c));
                    check("sb16_zero", 32'(oz16), 32'(e.z));
                end
            end
            if (v16 && rdy16) q16.push_back(model(16, 32'(d16), m16, int'(a16)));

            if (ov32 && or32) begin
                if (q32.size() == 0) begin
                    check("sb32_underflow", 32'd1, 32'd0);
                end else begin
                    e = q32.pop_front();
                    check("sb32_data", od32, e.d);
                    check("sb32_carry", 32'(oc32), 32'(e.c));
                    check("sb32_zero", 32'(oz32), 32'(e.z));
                end
            end
            if (v32 && rdy32) q32.push_back(model(32, d32, m32, int'(a32)));
        end
    end

    // Issues one op to the idle 16-bit pipe and checks latency and result against constants.
    task automatic dir16(input string tag, input logic [15:0] d, input logic [1:0] m,
                         input logic [3:0] a, input logic [15:0] ed, input logic ec,
                         input logic ez);
        int lat;
        or16 = 1'b1;
        v16  = 1'b1; d16 = d; m16 = m; a16 = a;
        @(posedge clk); #1;
        v16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_data"}, 32'(od16), 32'(ed));
        check({tag, "_carry"}, 32'(oc16), 32'(ec));
        check({tag, "_zero"}, 32'(oz16), 32'(ez));
    endtask

    task automatic dir32(input string tag, input logic [31:0] d, input logic [1:0] m,
                         input logic [4:0] a, input logic [31:0] ed, input logic ec);
        int lat;
        or32 = 1'b1;
        v32  = 1'b1; d32 = d; m32 = m; a32 = a;
        @(posedge clk); #1;
        v32 = 1'b0;
        lat = 1;
        while (!ov32 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check({tag, "_data"}, od32, ed);
        check({tag, "_carry"}, 32'(oc32), 32'(ec));
    endtask

    initial begin
        int sent, stall, seen, base, cyc, nacc;
        logic acc;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", 32'(ov16), 32'd0);
        check("rst_out_data", 32'(od16), 32'd0);
        check("rst_out_cz", 32'({oc16, oz16}), 32'd0);
        check("rst_in_ready", 32'(rdy16), 32'd1);
        check("rst32_out_valid", 32'(ov32), 32'd0);

        // Directed vectors
        dir16("ror_1234_4", 16'h1234, 2'b10, 4'd4, 16'h4123, 1'b0, 1'b0);
        dir16("rol_8001_1", 16'h8001, 2'b00, 4'd1, 16'h0003, 1'b1, 1'b0);
        dir16("sll_00f0_12", 16'h00F0, 2'b01, 4'd12, 16'h0000, 1'b1, 1'b1);
        dir16("srl_ffff_8", 16'hFFFF, 2'b11, 4'd8, 16'h00FF, 1'b1, 1'b0);
        dir16("rol_abcd_0", 16'hABCD, 2'b00, 4'd0, 16'hABCD, 1'b0, 1'b0);
        dir16("sll_abcd_0", 16'hABCD, 2'b01, 4'd0, 16'hABCD, 1'b0, 1'b0);
        dir16("ror_abcd_0", 16'hABCD, 2'b10, 4'd0, 16'hABCD, 1'b0, 1'b0);
        dir16("srl_abcd_0", 16'hABCD, 2'b11, 4'd0, 16'hABCD, 1'b0, 1'b0);
        dir16("ror_0001_15", 16'h0001, 2'b10, 4'd15, 16'h0002, 1'b0, 1'b0);
        dir16("srl_c000_15", 16'hC000, 2'b11, 4'd15, 16'h0001, 1'b1, 1'b0);
        dir16("sll_0003_15", 16'h0003, 2'b01, 4'd15, 16'h8000, 1'b1, 1'b0);
        dir32("sll32_1_31", 32'h0000_0001, 2'b01, 5'd31, 32'h8000_0000, 1'b0);
        dir32("ror32_1_1", 32'h0000_0001, 2'b10, 5'd1, 32'h8000_0000, 1'b1);
        repeat (6) @(posedge clk);
        #1;

        // Six back-to-back ops, consumer stalls 3 cycles after the first result
        sent = 0; stall = 0; seen = 0; cyc = 0;
        base = n_out16;
        while ((sent < 6 || n_out16 < base + 6) && cyc < 60) begin
            if (ov16 && seen == 0) begin
                seen  = 1;
                stall = 3;
            end
            or16 = (stall == 0);
            if (stall > 0) stall--;
            v16 = (sent < 6);
            d16 = 16'h1000 + 16'(sent) * 16'h0321;
            m16 = 2'(sent);
            a16 = 4'(sent * 3 + 1);
            @(negedge clk);
            if (!or16) check("stall_in_ready", 32'(rdy16), 32'd0);
            if (v16 && rdy16) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        v16  = 1'b0;
        or16 = 1'b1;
        check("stream_count", 32'(n_out16 - base), 32'd6);
        repeat (3) @(posedge clk);
        #1;

        // Reset while three ops are in flight
        for (int i = 0; i < 3; i++) begin
            v16 = 1'b1; d16 = 16'h00FF << i; m16 = 2'(i); a16 = 4'(i + 2);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        v16 = 1'b0;
        check("post_rst_in_ready", 32'(rdy16), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("post_rst_no_valid", 32'(ov16), 32'd0);
            @(posedge clk); #1;
        end
        dir16("post_rst_srl", 16'h8421, 2'b11, 4'd5, 16'h0421, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Random regression with random in_valid / out_ready
        nacc = 0; cyc = 0; acc = 1'b1;
        while (nacc < 10000 && cyc < 60000) begin
            if (!v16 || acc) begin
                v16 = ($urandom_range(3) != 0);
                d16 = 16'($urandom);
                m16 = 2'($urandom_range(3));
                a16 = 4'($urandom_range(15));
            end
            or16 = ($urandom_range(3) != 0);
            v32  = ($urandom_range(1) != 0);
            d32  = $urandom;
            m32  = 2'($urandom_range(3));
            a32  = 5'($urandom_range(31));
            or32 = ($urandom_range(2) != 0);
            @(negedge clk);
            acc = v16 && rdy16;
            if (acc) nacc++;
            @(posedge clk); #1;
            cyc++;
        end
        check("random_accepted", 32'(nacc), 32'd10000);
        v16 = 1'b0; or16 = 1'b1;
        v32 = 1'b0; or32 = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("drain16_empty", 32'(q16.size()), 32'd0);
        check("drain32_empty", 32'(q32.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/shift_rot_pipe.md
Name: shift_rot_pipe

Overview:
Parametrised, pipelined barrel shifter/rotator for the execute stage. It supports rotate-left, shift-left-logical, rotate-right and shift-right-logical on a WIDTH-bit operand. There is one register stage per shift-amount bit, with a valid/ready handshake on both sides. Alongside the result it produces a carry-out (last bit shifted or rotated out) and a zero flag.

Parameters:
WIDTH, 16, operand width; power of two, >= 4
AW (localparam), $clog2(WIDTH), shift-amount width and pipeline depth

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  block accepts operation this cycle
in_data  input  WIDTH  operand
shift_amnt  input  AW  shift/rotate amount, 0..WIDTH-1
mode  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRL
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  result
out_carry  output  1  last bit shifted/rotated out; 0 if amount 0
out_zero  output  1  out_data == 0

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous, active-high, and has priority over all other activity.
- Pipeline structure:
  - AW stages, S0..S(AW-1).
  - Stage k holds: valid, data, carry, mode, and the remaining amount bits.
  - Stage k shifts by 2^k when amount bit k = 1; otherwise it passes data and carry through unchanged.
  - S(AW-1) registers drive out_data, out_carry, out_zero and out_valid directly. out_zero is computed from the stage-k result before registering, not from the output register.
- Per-stage operation when shifting by 2^k (d = stage input data):
  - ROL: d rotated left 2^k; carry = d[WIDTH-2^k].
  - SLL: d << 2^k, zero-fill; carry = d[WIDTH-2^k].
  - ROR: d rotated right 2^k; carry = d[2^k-1].
  - SRL: d >> 2^k, zero-fill; carry = d[2^k-1].
  - Carry entering S0 is 0. Net result: carry = the last bit out of the full shift (left shift by n: original bit WIDTH-n; right shift by n: original bit n-1).
- Handshake and flow control:
  - Global advance: adv = !out_valid || out_ready.
  - in_ready = adv. This path is combinational from out_ready and out_valid.
  - When adv = 1, every stage loads from its predecessor; S0 loads in_valid plus operands.
  - When adv = 0, all stages hold.
  - Bubbles are not collapsed.
  - An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Latency and throughput:
  - Latency is exactly AW cycles from input acceptance to out_valid, with no stall.
  - Throughput is 1 operation per cycle while out_ready = 1.
  - Results emerge in acceptance order. No operation is lost or duplicated under any out_ready pattern.
- Output stability: while out_valid = 1 and out_ready = 0, out_data, out_carry and out_zero hold constant.
- Reset values:
  - All stage valid bits = 0, data = 0, carry = 0.
  - Outputs: out_valid = 0, out_data = 0, out_carry = 0, out_zero = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation: in-flight operations are discarded. There is no out_valid pulse for them after reset.
- Edge cases:
  - Amount 0: out_data = in_data and out_carry = 0, for all modes.
  - Amount WIDTH-1 is legal for all modes.
  - Stage data with valid = 0 is don't-care, except under reset.

Test Plan:
- WIDTH=16, ROR 0x1234 by 4, out_ready=1 -> after 4 cycles out_valid=1, out_data=0x4123, out_carry=0, out_zero=0.
- ROL 0x8001 by 1 -> 0x0003, carry=1. SLL 0x00F0 by 12 -> 0x0000, carry=1, zero=1. SRL 0xFFFF by 8 -> 0x00FF, carry=1. Any mode with 0xABCD by 0 -> 0xABCD, carry=0.
- Stream of 6 back-to-back operations with out_ready=0 for 3 cycles after the first result -> in_ready=0 during the stall, outputs held stable, all 6 results in order, no drops or duplicates.
- Issue 3 operations, assert rst for 1 cycle with in_valid=1 -> out_valid stays 0 for 8 cycles, in_ready=1 after reset, and a new operation completes normally.
- WIDTH=32 instance: SLL 0x00000001 by 31 -> 0x80000000, carry=0, latency 5. ROR 0x00000001 by 1 -> 0x80000000, carry=1.
- Random regression of 10k operations vs a reference model with random in_valid/out_ready -> all data, carry and zero values match, and order is preserved.
